// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared camera pipeline types and widths
//
// Purpose : common definitions for the camera capture/processing stages.
// Contents: DATA_W_DEF   default raw/gray pixel width
//           sum_w()      width of a 2x2 quad sum of pixels of a given width
//           quad_pos_e   position of a pixel inside its Bayer 2x2 quad
package cam_pkg;

  localparam int DATA_W_DEF = 12;

  // Four DATA_W-bit values summed can never need more than two extra bits.
  localparam int QUAD_SUM_EXTRA = 2;

  function automatic int sum_w(input int data_w);
    return data_w + QUAD_SUM_EXTRA;
  endfunction

  // Encoded as {row_odd, col_odd} so it can be cast straight from those bits.
  typedef enum logic [1:0] {
    EVEN_ROW_EVEN_COL = 2'b00,
    EVEN_ROW_ODD_COL  = 2'b01,
    ODD_ROW_EVEN_COL  = 2'b10,
    ODD_ROW_ODD_COL   = 2'b11
  } quad_pos_e;

endpackage

// File: rtl/bayer_line_buf.sv
// rtl/bayer_line_buf.sv - single-port line buffer RAM for one raw Bayer line
//
// Purpose : holds the even (GR) row so it can be paired with the odd (BG) row.
//           Read-first single-port RAM with registered read data, written so
//           that it maps onto a block RAM.
// Ports   : clk    rising-edge clock
//           we     write enable
//           addr   word address (raw column)
//           wdata  write data
//           rdata  registered read data of addr from the previous cycle
module bayer_line_buf #(
  parameter int DEPTH  = 1280,
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on purpose: contents are don't-care until written, and a reset
  // would prevent block RAM inference.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bayer_to_gray.sv
// rtl/bayer_to_gray.sv - 2x2 Bayer quad averaging to half-resolution gray
//
// Purpose : converts a GR/BG Bayer stream into gray pixels, one per 2x2 quad,
//           gray = (R + G1 + G2 + B) >> 2. Even rows are parked in a line
//           buffer; odd rows pair with them and emit RAW_W/2 pixels per line.
// Ports   : iCLK       rising-edge clock
//           iRST       asynchronous active-high reset
//           iFVAL      frame valid
//           iDVAL      raw pixel valid (qualified by iFVAL)
//           iRAW       raw Bayer pixel
//           oDVAL      gray pixel valid, one cycle per quad
//           oGRAY      gray pixel (holds when oDVAL=0)
//           oCOL       output column of oGRAY (holds when oDVAL=0)
//           oLINE_END  pulses with the last oDVAL of each output line
module bayer_to_gray
  import cam_pkg::*;
#(
  parameter int RAW_W  = 1280,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                         iCLK,
  input  logic                         iRST,
  input  logic                         iFVAL,
  input  logic                         iDVAL,
  input  logic [DATA_W-1:0]            iRAW,
  output logic                         oDVAL,
  output logic [DATA_W-1:0]            oGRAY,
  output logic [$clog2(RAW_W/2)-1:0]   oCOL,
  output logic                         oLINE_END
);

  localparam int ADDR_W = $clog2(RAW_W);
  localparam int COL_W  = $clog2(RAW_W/2);
  localparam int SUM_W  = sum_w(DATA_W);

  // ---------------------------------------------------------------------------
  // Raw position tracking
  // ---------------------------------------------------------------------------
  logic              accept;
  logic [ADDR_W-1:0] col;
  logic              row_odd;

  assign accept = iFVAL & iDVAL;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      col     <= '0;
      row_odd <= 1'b0;
    end else if (!iFVAL) begin
      // Any frame-invalid cycle restarts the mosaic at row 0, column 0.
      col     <= '0;
      row_odd <= 1'b0;
    end else if (iDVAL) begin
      if (col == ADDR_W'(RAW_W - 1)) begin
        col     <= '0;
        row_odd <= ~row_odd;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffer: even rows write, odd rows read the same column
  // ---------------------------------------------------------------------------
  logic              buf_we;
  logic [DATA_W-1:0] buf_rdata;

  assign buf_we = accept & ~row_odd;

  bayer_line_buf #(
    .DEPTH  (RAW_W),
    .DATA_W (DATA_W)
  ) u_line_buf (
    .clk   (iCLK),
    .we    (buf_we),
    .addr  (col),
    .wdata (iRAW),
    .rdata (buf_rdata)
  );

  // ---------------------------------------------------------------------------
  // Stage 1: accepted pixel aligned with the buffer read of its column.
  // buf_rdata is only meaningful in the cycle right after the accept, so
  // everything that consumes it is qualified by s1_valid.
  // ---------------------------------------------------------------------------
  logic              s1_valid;
  quad_pos_e         s1_pos;
  logic [ADDR_W-1:0] s1_col;
  logic [DATA_W-1:0] s1_pix;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s1_valid <= 1'b0;
      s1_pos   <= EVEN_ROW_EVEN_COL;
      s1_col   <= '0;
      s1_pix   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_pos <= quad_pos_e'({row_odd, col[0]});
        s1_col <= col;
        s1_pix <= iRAW;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Quad assembly: the left column of a quad is held until its right column
  // arrives, then all four pixels are summed.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] hold_odd;
  logic [DATA_W-1:0] hold_even;
  logic [SUM_W-1:0]  quad_sum;
  logic              s1_last;
  logic              emit;

  assign quad_sum = SUM_W'(hold_even) + SUM_W'(buf_rdata)
                  + SUM_W'(hold_odd)  + SUM_W'(s1_pix);

  assign s1_last = (s1_col == ADDR_W'(RAW_W - 1));

  // A quad still in flight when the frame drops belongs to a partial line and
  // is dropped; the final quad of a completed line is still delivered.
  assign emit = s1_valid && (s1_pos == ODD_ROW_ODD_COL) && (iFVAL || s1_last);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      hold_odd  <= '0;
      hold_even <= '0;
    end else if (s1_valid && (s1_pos == ODD_ROW_EVEN_COL)) begin
      hold_odd  <= s1_pix;
      hold_even <= buf_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs; gray and column hold between valid pulses.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDVAL     <= 1'b0;
      oLINE_END <= 1'b0;
      oGRAY     <= '0;
      oCOL      <= '0;
    end else begin
      oDVAL     <= emit;
      oLINE_END <= emit & s1_last;
      if (emit) begin
        oGRAY <= DATA_W'(quad_sum >> 2);
        oCOL  <= COL_W'(s1_col >> 1);
      end
    end
  end

endmodule

// File: tb/tb_bayer_to_gray.sv
// tb/tb_bayer_to_gray.sv - self-checking bench for bayer_to_gray
module tb_bayer_to_gray;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // small instance (RAW_W=4)
  logic        rst_s = 1'b1, fval_s = 1'b0, dval_s = 1'b0;
  logic [11:0] raw_s = '0;
  logic        odval_s, ole_s;
  logic [11:0] ogray_s;
  logic [0:0]  ocol_s;

  // full-size instance (RAW_W=1280)
  logic        rst_b = 1'b1, fval_b = 1'b0, dval_b = 1'b0;
  logic [11:0] raw_b = '0;
  logic        odval_b, ole_b;
  logic [11:0] ogray_b;
  logic [9:0]  ocol_b;

  bayer_to_gray #(.RAW_W(4), .DATA_W(12)) dut_s (
    .iCLK(clk), .iRST(rst_s), .iFVAL(fval_s), .iDVAL(dval_s), .iRAW(raw_s),
    .oDVAL(odval_s), .oGRAY(ogray_s), .oCOL(ocol_s), .oLINE_END(ole_s));

  bayer_to_gray #(.RAW_W(1280), .DATA_W(12)) dut_b (
    .iCLK(clk), .iRST(rst_b), .iFVAL(fval_b), .iDVAL(dval_b), .iRAW(raw_b),
    .oDVAL(odval_b), .oGRAY(ogray_b), .oCOL(ocol_b), .oLINE_END(ole_b));

  int nchk = 0, nfail = 0;

  typedef struct {int due; int gray; int col; bit le;} exp_t;
  exp_t qs[$], qb[$];

  int mrow[2], mcol[2];
  int evenl[2][1280];
  int oddl[2][1280];

  int obs_s[$], obs_cyc_s[$], obs_col_s[$];
  int le_s = 0, cnt_b = 0, le_b = 0;
  int stim[$], drv_cyc[$];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: pixels stored by (row parity, column) of the frame;
  // every odd-row odd-column pixel closes a quad that must appear 2 cycles on.
  task automatic model_accept(input int d, input int v);
    int w = (d != 0) ? 1280 : 4;
    int c = mcol[d];
    exp_t e;
    if (mrow[d] % 2 == 0) begin
      evenl[d][c] = v;
    end else begin
      oddl[d][c] = v;
      if (c % 2 == 1) begin
        e.due  = cyc + 2;
        e.gray = (evenl[d][c-1] + evenl[d][c] + oddl[d][c-1] + v) / 4;
        e.col  = c / 2;
        e.le   = (c == w - 1);
        if (d == 0) qs.push_back(e); else qb.push_back(e);
      end
    end
    mcol[d] = c + 1;
    if (mcol[d] == w) begin
      mcol[d] = 0;
      mrow[d]++;
    end
  endtask

  // Frame drop: the position restarts and quads of the unfinished line vanish.
  task automatic model_abort(input int d);
    exp_t keep[$];
    mrow[d] = 0;
    mcol[d] = 0;
    if (d == 0) begin
      foreach (qs[i]) if (qs[i].due <= cyc || qs[i].le) keep.push_back(qs[i]);
      qs = keep;
    end else begin
      foreach (qb[i]) if (qb[i].due <= cyc || qb[i].le) keep.push_back(qb[i]);
      qb = keep;
    end
  endtask

  task automatic model_reset(input int d);
    mrow[d] = 0;
    mcol[d] = 0;
    if (d == 0) qs.delete(); else qb.delete();
  endtask

  task automatic drive(input int d, input bit f, input bit v, input int x);
    @(posedge clk);
    #1;
    if (d == 0) begin
      fval_s = f; dval_s = v; raw_s = 12'(x);
    end else begin
      fval_b = f; dval_b = v; raw_b = 12'(x);
    end
    if (f && v) model_accept(d, x);
    else if (!f) model_abort(d);
  endtask

  task automatic idle(input int d, input int n, input bit f);
    repeat (n) drive(d, f, 1'b0, 0);
  endtask

  task automatic send_stim(input int d, input int gap);
    drv_cyc.delete();
    foreach (stim[i]) begin
      drive(d, 1'b1, 1'b1, stim[i]);
      drv_cyc.push_back(cyc);
      idle(d, gap, 1'b1);
    end
  endtask

  task automatic clear_obs();
    obs_s.delete(); obs_cyc_s.delete(); obs_col_s.delete();
    le_s = 0;
  endtask

  task automatic check_basic(input string tag);
    chk({tag, "_count"}, obs_s.size(), 2);
    chk({tag, "_line_end_count"}, le_s, 1);
    if (obs_s.size() == 2) begin
      chk({tag, "_gray0"}, obs_s[0], 350);
      chk({tag, "_gray1"}, obs_s[1], 550);
      chk({tag, "_col0"}, obs_col_s[0], 0);
      chk({tag, "_col1"}, obs_col_s[1], 1);
    end
  endtask

  // Single compare process: every cycle, each DUT output against the model.
  task automatic check_out(input int d, input logic dv, input int g, input int c,
                           input logic le);
    exp_t e;
    int n;
    e = '{default: 0};
    n = (d == 0) ? qs.size() : qb.size();
    while (n > 0) begin
      if (d == 0) e = qs[0]; else e = qb[0];
      if (e.due >= cyc) break;
      chk($sformatf("dut%0d_missing_out_col%0d", d, e.col), 0, 1);
      if (d == 0) qs.delete(0); else qb.delete(0);
      n--;
    end
    if (n > 0 && e.due == cyc) begin
      chk($sformatf("dut%0d_dval_col%0d", d, e.col), int'(dv), 1);
      chk($sformatf("dut%0d_gray_col%0d", d, e.col), g, e.gray);
      chk($sformatf("dut%0d_col", d), c, e.col);
      chk($sformatf("dut%0d_line_end_col%0d", d, e.col), int'(le), int'(e.le));
      if (d == 0) qs.delete(0); else qb.delete(0);
    end else begin
      chk($sformatf("dut%0d_idle_dval", d), int'(dv), 0);
      chk($sformatf("dut%0d_idle_line_end", d), int'(le), 0);
    end
    if (dv === 1'b1) begin
      if (d == 0) begin
        obs_s.push_back(g); obs_cyc_s.push_back(cyc); obs_col_s.push_back(c);
        if (le === 1'b1) le_s++;
      end else begin
        cnt_b++;
        if (le === 1'b1) le_b++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_s) check_out(0, odval_s, int'(ogray_s), int'(ocol_s), ole_s);
    if (!rst_b) check_out(1, odval_b, int'(ogray_b), int'(ocol_b), ole_b);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", nchk);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dval", int'(odval_s), 0);
    chk("rst_gray", int'(ogray_s), 0);
    chk("rst_col", int'(ocol_s), 0);
    chk("rst_line_end", int'(ole_s), 0);
    chk("rst_big_dval", int'(odval_b), 0);
    rst_s = 1'b0;
    rst_b = 1'b0;

    // basic quad averaging with exact latency
    clear_obs();
    stim = '{100, 200, 300, 400, 500, 600, 700, 800};
    send_stim(0, 0);
    idle(0, 4, 1'b1);
    idle(0, 2, 1'b0);
    check_basic("basic");
    if (obs_s.size() == 2) begin
      chk("basic_latency0", obs_cyc_s[0] - drv_cyc[5], 2);
      chk("basic_latency1", obs_cyc_s[1] - drv_cyc[7], 2);
    end
    chk("hold_gray", int'(ogray_s), 550);
    chk("hold_col", int'(ocol_s), 1);

    // saturation range
    clear_obs();
    stim = '{4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095};
    send_stim(0, 0);
    idle(0, 4, 1'b1);
    idle(0, 2, 1'b0);
    chk("sat_max_count", obs_s.size(), 2);
    foreach (obs_s[i]) chk($sformatf("sat_max_gray%0d", i), obs_s[i], 4095);
    clear_obs();
    stim = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_stim(0, 0);
    idle(0, 4, 1'b1);
    idle(0, 2, 1'b0);
    chk("sat_zero_count", obs_s.size(), 2);
    foreach (obs_s[i]) chk($sformatf("sat_zero_gray%0d", i), obs_s[i], 0);

    // gapped input
    clear_obs();
    stim = '{100, 200, 300, 400, 500, 600, 700, 800};
    send_stim(0, 3);
    idle(0, 4, 1'b1);
    idle(0, 2, 1'b0);
    check_basic("gapped");

    // frame abort after two pixels of row 1, then a full frame
    clear_obs();
    stim = '{100, 200, 300, 400, 500, 600};
    send_stim(0, 0);
    idle(0, 3, 1'b0);
    stim = '{100, 200, 300, 400, 500, 600, 700, 800};
    send_stim(0, 0);
    idle(0, 4, 1'b1);
    idle(0, 2, 1'b0);
    check_basic("abort");

    // asynchronous reset mid-line while outputs hold nonzero values
    clear_obs();
    stim = '{100, 200, 300, 400, 500, 600};
    send_stim(0, 0);
    @(posedge clk);
    #2;
    rst_s = 1'b1;
    dval_s = 1'b0;
    model_reset(0);
    #1;
    chk("midrst_dval", int'(odval_s), 0);
    chk("midrst_gray", int'(ogray_s), 0);
    chk("midrst_col", int'(ocol_s), 0);
    chk("midrst_line_end", int'(ole_s), 0);
    @(posedge clk);
    #1;
    rst_s = 1'b0;
    stim = '{100, 200, 300, 400, 500, 600, 700, 800};
    send_stim(0, 0);
    idle(0, 4, 1'b1);
    idle(0, 2, 1'b0);
    check_basic("midrst");

    // random frames with random gaps on the small instance
    for (int f = 0; f < 4; f++) begin
      stim.delete();
      for (int i = 0; i < 16; i++) stim.push_back(int'($urandom_range(0, 4095)));
      send_stim(0, int'($urandom_range(0, 2)));
      idle(0, 3, 1'b1);
      idle(0, 2, 1'b0);
    end

    // full-size cadence: 4 random lines of 1280 pixels, occasional gaps
    for (int i = 0; i < 4 * 1280; i++) begin
      drive(1, 1'b1, 1'b1, int'($urandom_range(0, 4095)));
      if ($urandom_range(0, 7) == 0) idle(1, int'($urandom_range(1, 3)), 1'b1);
    end
    idle(1, 4, 1'b1);
    idle(1, 2, 1'b0);
    chk("full_pulse_count", cnt_b, 1280);
    chk("full_line_end_count", le_b, 2);
    chk("small_queue_drained", qs.size(), 0);
    chk("full_queue_drained", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
